// File: rtl/digest_serializer_if.sv
// ----------------------------------------------------------------------------
// digest_serializer_if
//   Bundles the two handshakes of the digest serializer into one interface:
//   the capture side facing f_permutation and the word stream facing the user.
//   Signal prefixes are from the serializer's point of view (i_ = into the
//   serializer, o_ = out of it).
//
//   i_stateBus  [IN_WIDTH]  wide hash state from f_permutation
//   i_inReady   [1]         digest on i_stateBus is final, held until o_inAck
//   o_inAck     [1]         capture strobe back to f_permutation
//   o_outData   [32]        current digest word
//   o_outValid  [1]         o_outData holds a valid word
//   i_outReady  [1]         user accepts o_outData this cycle
//   o_outLast   [1]         o_outData is the final word of the digest
//
//   slave  : serializer view
//   master : environment view (f_permutation + user side)
// ----------------------------------------------------------------------------
interface digest_serializer_if #(
    parameter int IN_WIDTH = 576
);
    logic [IN_WIDTH-1:0] i_stateBus;
    logic                i_inReady;
    logic                o_inAck;
    logic [31:0]         o_outData;
    logic                o_outValid;
    logic                i_outReady;
    logic                o_outLast;

    modport slave (
        input  i_stateBus,
        input  i_inReady,
        input  i_outReady,
        output o_inAck,
        output o_outData,
        output o_outValid,
        output o_outLast
    );

    modport master (
        output i_stateBus,
        output i_inReady,
        output i_outReady,
        input  o_inAck,
        input  o_outData,
        input  o_outValid,
        input  o_outLast
    );
endinterface

// File: rtl/digest_serializer.sv
// ----------------------------------------------------------------------------
// digest_serializer
//   Output-side counterpart of the input padder. When f_permutation signals
//   that its state holds a final digest, the top 32*DIGEST_WORDS bits are
//   captured into a shift buffer and streamed to the user as 32-bit words,
//   most significant word first, under a valid/ready handshake.
//
//   Parameters
//     IN_WIDTH      width of the f_permutation state bus
//     DIGEST_WORDS  32-bit words per digest (32*DIGEST_WORDS <= IN_WIDTH)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    digest_serializer_if.slave (capture handshake + word stream)
// ----------------------------------------------------------------------------
module digest_serializer #(
    parameter int IN_WIDTH     = 576,
    parameter int DIGEST_WORDS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    digest_serializer_if.slave bus
);

    localparam int DIGEST_BITS = 32 * DIGEST_WORDS;
    localparam int COUNT_WIDTH = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DIGEST_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  r_state;
    logic [DIGEST_BITS-1:0]  r_buf;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    r_outValid;
    logic                    r_outLast;

    logic                    w_handshake;
    logic                    w_lastHandshake;
    logic                    w_capture;
    logic [DIGEST_BITS-1:0]  w_digest;
    logic [COUNT_WIDTH-1:0]  w_countNext;
    logic                    w_unusedLow;

    assign w_digest        = bus.i_stateBus[IN_WIDTH-1 -: DIGEST_BITS];
    assign w_handshake     = r_outValid & bus.i_outReady;
    assign w_lastHandshake = w_handshake & r_outLast;
    assign w_countNext     = r_count + COUNT_WIDTH'(1);

    // A new digest may be taken when idle, or in the very cycle the last word
    // of the current digest is accepted so back-to-back digests leave no gap.
    // Gating with rst_n keeps the acknowledge quiet while reset is held.
    assign w_capture = rst_n & bus.i_inReady &
                       ((r_state == IDLE) | ((r_state == SEND) & w_lastHandshake));

    // State bits below the digest slice are intentionally not consumed.
    generate
        if (IN_WIDTH > DIGEST_BITS) begin : g_lowBits
            assign w_unusedLow = ^bus.i_stateBus[IN_WIDTH-DIGEST_BITS-1:0];
        end else begin : g_noLowBits
            assign w_unusedLow = 1'b0;
        end
    endgenerate

    // Output word and flags come only from registers; the acknowledge is the
    // one deliberately combinational path back to f_permutation.
    assign bus.o_inAck    = w_capture;
    assign bus.o_outData  = r_buf[DIGEST_BITS-1 -: 32];
    assign bus.o_outValid = r_outValid;
    assign bus.o_outLast  = r_outLast;

    // Serializer FSM. The buffer shifts left one word per accepted word, so
    // the current word is always the top 32 bits. out_last is precomputed
    // from the next count so it is a plain register at the output. When the
    // last word is accepted without a new capture the buffer shifts out to
    // zero, leaving the output word cleared while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_count    <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else if (w_capture) begin
            r_state    <= SEND;
            r_buf      <= w_digest;
            r_count    <= '0;
            r_outValid <= 1'b1;
            r_outLast  <= (DIGEST_WORDS == 1);
        end else if (w_handshake) begin
            r_buf <= r_buf << 32;
            if (r_outLast) begin
                r_state    <= IDLE;
                r_count    <= '0;
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end else begin
                r_count   <= w_countNext;
                r_outLast <= (w_countNext == LAST_COUNT);
            end
        end
    end

endmodule

// File: tb/tb_digest_serializer.sv
// ----------------------------------------------------------------------------
// tb_digest_serializer
//   Self-checking bench for digest_serializer. Two instances are exercised:
//   a 16-word (512-bit) digest and an 8-word (256-bit) digest, both on a
//   576-bit state bus. Digests are built so that word k of a digest equals
//   base + k, counting from the top of the state bus downwards.
// ----------------------------------------------------------------------------
module tb_digest_serializer;

    localparam int IN_WIDTH = 576;

    logic clk = 1'b0;
    logic rst_n;

    int checks     = 0;
    int failures   = 0;
    int handshakes = 0;

    always #5 clk = ~clk;

    digest_serializer_if #(.IN_WIDTH(IN_WIDTH)) bus16 ();
    digest_serializer_if #(.IN_WIDTH(IN_WIDTH)) bus8 ();

    digest_serializer #(.IN_WIDTH(IN_WIDTH), .DIGEST_WORDS(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    digest_serializer #(.IN_WIDTH(IN_WIDTH), .DIGEST_WORDS(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    typedef struct {
        logic        inReady;
        logic        outReady;
        logic [31:0] digestBase;
        logic        expInAck;
        logic        expValid;
        logic [31:0] expData;
        logic        expLast;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    // Word k (k = 0 at the top of the bus) carries base + k over the whole
    // bus, so a wrongly placed slice shows up as a wrong word value.
    function automatic logic [IN_WIDTH-1:0] makeDigest(input logic [31:0] base);
        logic [IN_WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < IN_WIDTH / 32; k++) begin
            d[IN_WIDTH-1-32*k -: 32] = base + 32'(k);
        end
        return d;
    endfunction

    function automatic void addVec(input logic inReady, input logic outReady,
                                   input logic [31:0] base, input logic expInAck,
                                   input logic expValid, input logic [31:0] expData,
                                   input logic expLast, input string tag);
        vec_t v;
        v.inReady    = inReady;
        v.outReady   = outReady;
        v.digestBase = base;
        v.expInAck   = expInAck;
        v.expValid   = expValid;
        v.expData    = expData;
        v.expLast    = expLast;
        v.tag        = tag;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs at the falling edge; outputs are then sampled
    // 1 time unit later, well clear of the next rising edge.
    task automatic applyStimulus(input bit sel8, input logic inReady,
                                 input logic outReady, input logic [31:0] base);
        @(negedge clk);
        if (sel8) begin
            bus8.i_inReady  = inReady;
            bus8.i_outReady = outReady;
            bus8.i_stateBus = makeDigest(base);
        end else begin
            bus16.i_inReady  = inReady;
            bus16.i_outReady = outReady;
            bus16.i_stateBus = makeDigest(base);
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkCycle(input bit sel8, input string tag, input logic expAck,
                              input logic expValid, input logic [31:0] expData,
                              input logic expLast);
        logic        ack;
        logic        valid;
        logic        last;
        logic [31:0] data;
        if (sel8) begin
            ack = bus8.o_inAck;   valid = bus8.o_outValid;
            last = bus8.o_outLast; data = bus8.o_outData;
        end else begin
            ack = bus16.o_inAck;   valid = bus16.o_outValid;
            last = bus16.o_outLast; data = bus16.o_outData;
        end
        checkOutput({tag, " in_ack"}, 32'(ack), 32'(expAck));
        checkOutput({tag, " out_valid"}, 32'(valid), 32'(expValid));
        if (expValid) begin
            checkOutput({tag, " out"}, data, expData);
            checkOutput({tag, " out_last"}, 32'(last), 32'(expLast));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus16.i_inReady  = 1'b0;
        bus16.i_outReady = 1'b0;
        bus16.i_stateBus = '0;
        bus8.i_inReady   = 1'b0;
        bus8.i_outReady  = 1'b0;
        bus8.i_stateBus  = '0;

        // Reset held with in_ready asserted: nothing may be acknowledged or shown.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0000);
            bus8.i_inReady = 1'b1;
            #1;
            checkOutput("reset in_ack", 32'(bus16.o_inAck), 32'd0);
            checkOutput("reset out_valid", 32'(bus16.o_outValid), 32'd0);
            checkOutput("reset out", bus16.o_outData, 32'd0);
            checkOutput("reset out_last", 32'(bus16.o_outLast), 32'd0);
            checkOutput("reset in_ack 8w", 32'(bus8.o_inAck), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        bus8.i_inReady = 1'b0;
        rst_n = 1'b1;

        // Single digest with words 0..F, output always ready.
        addVec(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, "t2 capture");
        for (int k = 0; k < 16; k++)
            addVec(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'(k), (k == 15), "t2 word");
        addVec(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, "t2 idle");

        // Backpressure: out_ready pattern 1,0,0 repeating; the word must hold
        // through every stall and advance exactly once per accepted word.
        addVec(1'b1, 1'b0, 32'hA000_0000, 1'b1, 1'b0, 32'h0, 1'b0, "t3 capture");
        begin
            int idx = 0;
            int i   = 0;
            while (idx < 16) begin
                logic rdy;
                rdy = (i % 3 == 0);
                addVec(1'b0, rdy, 32'hA000_0000, 1'b0, 1'b1,
                       32'hA000_0000 + 32'(idx), (idx == 15), "t3 word");
                if (rdy) idx++;
                i++;
            end
        end
        addVec(1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0, 1'b0, "t3 idle");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b0, vecs[i].inReady, vecs[i].outReady, vecs[i].digestBase);
            if (vecs[i].digestBase == 32'hA000_0000 && bus16.o_outValid && vecs[i].outReady)
                handshakes++;
            checkCycle(1'b0, vecs[i].tag, vecs[i].expInAck, vecs[i].expValid,
                       vecs[i].expData, vecs[i].expLast);
        end
        checkOutput("t3 handshake count", 32'(handshakes), 32'd16);

        // Back-to-back: digest B waits with in_ready high while A streams.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        checkCycle(1'b0, "t4 capture A", 1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200);
            checkCycle(1'b0, "t4 A word", (k == 15), 1'b1, 32'h0000_0100 + 32'(k), (k == 15));
        end
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200);
            checkCycle(1'b0, "t4 B word", 1'b0, 1'b1, 32'h0000_0200 + 32'(k), (k == 15));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        checkCycle(1'b0, "t4 idle", 1'b0, 1'b0, 32'h0, 1'b0);

        // Mid-stream reset after word 5, then a fresh digest from word 0.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        checkCycle(1'b0, "t5 capture", 1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0300);
            checkCycle(1'b0, "t5 word", 1'b0, 1'b1, 32'h0000_0300 + 32'(k), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0300);
        checkCycle(1'b0, "t5 word6 stalled", 1'b0, 1'b1, 32'h0000_0306, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5 async out_valid", 32'(bus16.o_outValid), 32'd0);
        checkOutput("t5 async out", bus16.o_outData, 32'd0);
        checkOutput("t5 async out_last", 32'(bus16.o_outLast), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0400);
        checkCycle(1'b0, "t5 fresh capture", 1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0400);
            checkCycle(1'b0, "t5 fresh word", 1'b0, 1'b1, 32'h0000_0400 + 32'(k), (k == 15));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0400);
        checkCycle(1'b0, "t5 idle", 1'b0, 1'b0, 32'h0, 1'b0);

        // 8-word digest taken from the top 256 bits of the state bus.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0000);
        checkCycle(1'b1, "t6 capture", 1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h8000_0000);
            checkCycle(1'b1, "t6 word", 1'b0, 1'b1, 32'h8000_0000 + 32'(k), (k == 7));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8000_0000);
        checkCycle(1'b1, "t6 idle", 1'b0, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
